// File: rtl/salamander_pkg.sv
// Shared definitions for the color RAM CPU port: access state encoding and RAM geometry.
package salamander_pkg;

  localparam int COLORRAM_AW = 11;
  localparam int COLORRAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_ACCESS    = 2'd2,
    ST_ACK       = 2'd3
  } colorram_state_e;

endpackage

// File: rtl/colorram_cpu_port.sv
// 68000 access port to the color RAM: each CPU cycle borrows one whole pixel slot
// from the palette lookup, preferably during blanking to avoid on-screen snow.
module colorram_cpu_port
  import salamander_pkg::*;
#(
  parameter int SNOW_FREE  = 1,
  parameter int WAIT_LIMIT = 512
) (
  input  logic                   i_EMU_MCLK,
  input  logic                   i_MRST,
  input  logic                   i_EMU_CLK6MPCEN_n,
  input  logic                   i_BLK,
  input  logic [COLORRAM_AW-1:0] i_CD,
  input  logic                   i_COLORRAM_CS_n,
  input  logic                   i_CPU_AS_n,
  input  logic                   i_CPU_RW,
  input  logic                   i_CPU_UDS_n,
  input  logic                   i_CPU_LDS_n,
  input  logic [COLORRAM_AW-1:0] i_CPU_ADDR,
  input  logic [COLORRAM_DW-1:0] i_CPU_DIN,
  output logic [COLORRAM_DW-1:0] o_CPU_DOUT,
  output logic                   o_DTACK_n,
  output logic                   o_COLORRAM_n,
  output logic [COLORRAM_AW-1:0] o_RAM_ADDR,
  output logic [COLORRAM_DW-1:0] o_RAM_DIN,
  output logic                   o_RAM_WR_UDS_n,
  output logic                   o_RAM_WR_LDS_n,
  input  logic [COLORRAM_DW-1:0] i_RAM_DOUT
);

  colorram_state_e        state_q, state_d;
  logic [9:0]             cnt_q, cnt_d;
  logic [COLORRAM_AW-1:0] addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic                   uds_n_q, uds_n_d;
  logic                   lds_n_q, lds_n_d;
  logic [COLORRAM_DW-1:0] din_q, din_d;
  logic [COLORRAM_DW-1:0] dout_q, dout_d;
  logic                   dtack_n_q, dtack_n_d;
  logic                   colorram_n_q, colorram_n_d;
  logic                   wr_uds_n_q, wr_uds_n_d;
  logic                   wr_lds_n_q, wr_lds_n_d;

  logic        pix_en;
  logic        start;
  logic [10:0] cnt_inc;
  logic        limit_hit;
  logic        grant_ok;

  assign pix_en    = ~i_EMU_CLK6MPCEN_n;
  assign start     = ~i_COLORRAM_CS_n & ~i_CPU_AS_n & (~i_CPU_UDS_n | ~i_CPU_LDS_n);
  assign cnt_inc   = {1'b0, cnt_q} + 11'd1;
  assign limit_hit = (cnt_inc >= 11'(WAIT_LIMIT));
  assign grant_ok  = (SNOW_FREE == 0) | ~i_BLK | limit_hit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    uds_n_d      = uds_n_q;
    lds_n_d      = lds_n_q;
    din_d        = din_q;
    dout_d       = dout_q;
    dtack_n_d    = dtack_n_q;
    colorram_n_d = colorram_n_q;
    wr_uds_n_d   = wr_uds_n_q;
    wr_lds_n_d   = wr_lds_n_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = i_CPU_ADDR;
          rw_d    = i_CPU_RW;
          uds_n_d = i_CPU_UDS_n;
          lds_n_d = i_CPU_LDS_n;
          din_d   = i_CPU_DIN;
          cnt_d   = 10'd0;
          state_d = ST_WAIT_SLOT;
        end
      end
      ST_WAIT_SLOT: begin
        // An abandoned bus cycle wins over a simultaneous grant, so nothing touches the RAM.
        if (i_CPU_AS_n) begin
          state_d = ST_IDLE;
        end else if (pix_en) begin
          if (grant_ok) begin
            state_d      = ST_ACCESS;
            colorram_n_d = 1'b0;
            if (!rw_q) begin
              wr_uds_n_d = uds_n_q;
              wr_lds_n_d = lds_n_q;
            end
          end else if (cnt_q != 10'h3FF) begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      ST_ACCESS: begin
        // Once granted the slot always runs to the closing pixel enable.
        if (pix_en) begin
          if (rw_q) begin
            dout_d = i_RAM_DOUT;
          end
          colorram_n_d = 1'b1;
          wr_uds_n_d   = 1'b1;
          wr_lds_n_d   = 1'b1;
          if (i_CPU_AS_n) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_ACK;
            dtack_n_d = 1'b0;
          end
        end
      end
      ST_ACK: begin
        if (i_CPU_AS_n) begin
          dtack_n_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 10'd0;
      addr_q       <= '0;
      rw_q         <= 1'b1;
      uds_n_q      <= 1'b1;
      lds_n_q      <= 1'b1;
      din_q        <= '0;
      dout_q       <= '0;
      dtack_n_q    <= 1'b1;
      colorram_n_q <= 1'b1;
      wr_uds_n_q   <= 1'b1;
      wr_lds_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      uds_n_q      <= uds_n_d;
      lds_n_q      <= lds_n_d;
      din_q        <= din_d;
      dout_q       <= dout_d;
      dtack_n_q    <= dtack_n_d;
      colorram_n_q <= colorram_n_d;
      wr_uds_n_q   <= wr_uds_n_d;
      wr_lds_n_q   <= wr_lds_n_d;
    end
  end

  assign o_CPU_DOUT     = dout_q;
  assign o_DTACK_n      = dtack_n_q;
  assign o_COLORRAM_n   = colorram_n_q;
  assign o_RAM_ADDR     = colorram_n_q ? i_CD : addr_q;
  assign o_RAM_DIN      = din_q;
  assign o_RAM_WR_UDS_n = wr_uds_n_q;
  assign o_RAM_WR_LDS_n = wr_lds_n_q;

endmodule

// File: tb/tb_colorram_cpu_port.sv
// Bench for colorram_cpu_port: stimulus pushes expected slot results, a DTACK-driven monitor checks them.
module tb_colorram_cpu_port;

  localparam int PIX = 4;

  logic        clk, rst, cen_n, blk;
  logic [10:0] cd, addr;
  logic        cs_n, cs2_n, as_n, rw, uds_n, lds_n;
  logic [15:0] din;

  logic [15:0] dout, ram_din, ram_dout;
  logic        dtack_n, col_n, wr_uds_n, wr_lds_n;
  logic [10:0] ram_addr;

  logic [15:0] dout2, ram_din2;
  logic        dtack2_n, col2_n, wr_uds2_n, wr_lds2_n;
  logic [10:0] ram_addr2;

  logic [15:0] ram [0:2047];

  int n_tests = 0;
  int n_fail  = 0;
  int pix_div = 0;

  typedef struct {
    logic [10:0] addr;
    logic        is_read;
    logic [15:0] dout;
    logic [15:0] ram_val;
    logic        uds_low;
    logic        lds_low;
  } exp_t;

  exp_t exp_q[$];

  colorram_cpu_port #(.SNOW_FREE(1), .WAIT_LIMIT(512)) dut (
    .i_EMU_MCLK(clk), .i_MRST(rst), .i_EMU_CLK6MPCEN_n(cen_n), .i_BLK(blk), .i_CD(cd),
    .i_COLORRAM_CS_n(cs_n), .i_CPU_AS_n(as_n), .i_CPU_RW(rw), .i_CPU_UDS_n(uds_n),
    .i_CPU_LDS_n(lds_n), .i_CPU_ADDR(addr), .i_CPU_DIN(din), .o_CPU_DOUT(dout),
    .o_DTACK_n(dtack_n), .o_COLORRAM_n(col_n), .o_RAM_ADDR(ram_addr), .o_RAM_DIN(ram_din),
    .o_RAM_WR_UDS_n(wr_uds_n), .o_RAM_WR_LDS_n(wr_lds_n), .i_RAM_DOUT(ram_dout)
  );

  colorram_cpu_port #(.SNOW_FREE(1), .WAIT_LIMIT(4)) dut_lim (
    .i_EMU_MCLK(clk), .i_MRST(rst), .i_EMU_CLK6MPCEN_n(cen_n), .i_BLK(blk), .i_CD(cd),
    .i_COLORRAM_CS_n(cs2_n), .i_CPU_AS_n(as_n), .i_CPU_RW(rw), .i_CPU_UDS_n(uds_n),
    .i_CPU_LDS_n(lds_n), .i_CPU_ADDR(addr), .i_CPU_DIN(din), .o_CPU_DOUT(dout2),
    .o_DTACK_n(dtack2_n), .o_COLORRAM_n(col2_n), .o_RAM_ADDR(ram_addr2), .o_RAM_DIN(ram_din2),
    .o_RAM_WR_UDS_n(wr_uds2_n), .o_RAM_WR_LDS_n(wr_lds2_n), .i_RAM_DOUT(ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel enable: one MCLK wide, every PIX MCLKs.
  initial begin
    cen_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_div = (pix_div + 1) % PIX;
      cen_n   = (pix_div != 0);
    end
  end

  // Color RAM model with byte write enables and registered read.
  always @(posedge clk) begin
    if (!wr_uds_n) ram[ram_addr][15:8] <= ram_din[15:8];
    if (!wr_lds_n) ram[ram_addr][7:0]  <= ram_din[7:0];
    ram_dout <= ram[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: tracks each slot and scores it when DTACK falls.
  logic        prev_col = 1'b1, prev_dtack = 1'b1;
  int          slot_len = 0;
  logic [10:0] slot_addr = '0;
  logic        addr_moved = 1'b0, uds_seen = 1'b0, lds_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (col_n === 1'b0) begin
      if (prev_col !== 1'b0) begin
        slot_len   = 0;
        slot_addr  = ram_addr;
        addr_moved = 1'b0;
        uds_seen   = 1'b0;
        lds_seen   = 1'b0;
      end
      slot_len++;
      if (ram_addr !== slot_addr) addr_moved = 1'b1;
      if (wr_uds_n === 1'b0) uds_seen = 1'b1;
      if (wr_lds_n === 1'b0) lds_seen = 1'b1;
    end
    if (prev_dtack === 1'b1 && dtack_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_dtack: got DTACK low, expected no transaction at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("slot_len", 32'(slot_len), 32'(PIX));
        check("slot_addr", 32'(slot_addr), 32'(e.addr));
        check("slot_addr_stable", 32'(addr_moved), 32'd0);
        check("uds_strobe", 32'(uds_seen), 32'(e.uds_low));
        check("lds_strobe", 32'(lds_seen), 32'(e.lds_low));
        check("dtack_with_release", 32'({prev_col, col_n}), 32'b01);
        if (e.is_read) check("read_data", 32'(dout), 32'(e.dout));
        check("ram_contents", 32'(ram[e.addr]), 32'(e.ram_val));
        $display("[TB] txn %s addr=0x%03h dout=0x%04h ram=0x%04h slot=%0d",
                 e.is_read ? "RD" : "WR", e.addr, dout, ram[e.addr], slot_len);
      end
    end
    prev_col   = col_n;
    prev_dtack = dtack_n;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [10:0] a, input logic r, input logic [15:0] d,
                          input logic [15:0] rv, input logic ul, input logic ll);
    exp_t e;
    e.addr = a; e.is_read = r; e.dout = d; e.ram_val = rv; e.uds_low = ul; e.lds_low = ll;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [10:0] a, input logic r, input logic u_n,
                       input logic l_n, input logic [15:0] d);
    tick();
    addr = a; rw = r; uds_n = u_n; lds_n = l_n; din = d;
    cs_n = 1'b0; as_n = 1'b0;
  endtask

  task automatic release_bus();
    as_n = 1'b1; cs_n = 1'b1; cs2_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
  endtask

  task automatic finish_cycle(input string name);
    logic done = 1'b0;
    logic held = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (dtack_n === 1'b0) done = 1'b1;
    end
    check({name, "_dtack_seen"}, 32'(done), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (dtack_n !== 1'b0) held = 1'b0;
    end
    check({name, "_dtack_held"}, 32'(held), 32'd1);
    tick();
    release_bus();
    @(posedge clk);
    @(negedge clk);
    check({name, "_dtack_release"}, 32'(dtack_n), 32'd1);
  endtask

  initial begin
    int en_cnt, bad_grant, bad_addr, bad, n_en;
    logic granted, done;
    for (int i = 0; i < 2048; i++) ram[i] = 16'h0000;
    ram[11'h010] = 16'h1234;
    rst = 1'b1; blk = 1'b0; cd = 11'h2A5;
    cs_n = 1'b1; cs2_n = 1'b1; as_n = 1'b1; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    addr = '0; din = '0;

    repeat (3) @(negedge clk);
    check("rst_dtack", 32'(dtack_n), 32'd1);
    check("rst_colorram", 32'(col_n), 32'd1);
    check("rst_wr_uds", 32'(wr_uds_n), 32'd1);
    check("rst_wr_lds", 32'(wr_lds_n), 32'd1);
    check("rst_cpu_dout", 32'(dout), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_ram_addr_cd", 32'(ram_addr), 32'h2A5);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Word write during blanking.
    blk = 1'b0;
    push_exp(11'h123, 1'b0, 16'h0000, 16'h7FFF, 1'b1, 1'b1);
    start(11'h123, 1'b0, 1'b0, 1'b0, 16'h7FFF);
    finish_cycle("word_write");

    // Low-byte-only write merges into existing word.
    push_exp(11'h010, 1'b0, 16'h0000, 16'h12AB, 1'b0, 1'b1);
    start(11'h010, 1'b0, 1'b1, 1'b0, 16'h00AB);
    finish_cycle("lds_write");

    // Read held off by visible area for 100 pixel enables.
    blk = 1'b1;
    push_exp(11'h010, 1'b1, 16'h12AB, 16'h12AB, 1'b0, 1'b0);
    start(11'h010, 1'b1, 1'b0, 1'b0, 16'h0000);
    en_cnt = 0; bad_grant = 0; bad_addr = 0;
    while (en_cnt < 100) begin
      @(negedge clk);
      if (cen_n === 1'b0) en_cnt++;
      if (col_n !== 1'b1) bad_grant++;
      if (ram_addr !== cd) bad_addr++;
      cd = 11'(en_cnt * 37 + 5);
    end
    check("no_grant_while_visible", 32'(bad_grant), 32'd0);
    check("addr_follows_cd", 32'(bad_addr), 32'd0);
    blk = 1'b0;
    finish_cycle("snow_free_read");

    // Forced grant on the 4th enable after capture with WAIT_LIMIT=4.
    blk = 1'b1;
    tick();
    addr = 11'h055; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
    cs2_n = 1'b0; as_n = 1'b0;
    @(posedge clk);
    n_en = 0; granted = 1'b0;
    for (int i = 0; i < 200 && !granted; i++) begin
      @(negedge clk);
      if (col2_n === 1'b0) granted = 1'b1;
      else if (cen_n === 1'b0) n_en++;
    end
    check("limit_granted", 32'(granted), 32'd1);
    check("limit_grant_enable", 32'(n_en), 32'd4);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (dtack2_n === 1'b0) done = 1'b1;
    end
    check("limit_dtack_seen", 32'(done), 32'd1);
    tick();
    release_bus();
    @(posedge clk);
    @(negedge clk);
    check("limit_dtack_release", 32'(dtack2_n), 32'd1);
    blk = 1'b0;

    // Bus cycle abandoned while waiting for a slot.
    blk = 1'b1;
    start(11'h200, 1'b0, 1'b0, 1'b0, 16'h5555);
    repeat (10) @(negedge clk);
    tick();
    release_bus();
    blk = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (col_n !== 1'b1 || dtack_n !== 1'b1) bad++;
    end
    check("abort_no_access", 32'(bad), 32'd0);
    check("abort_no_write", 32'(ram[11'h200]), 32'h0000);

    // Reset pulse in the middle of a write slot.
    start(11'h300, 1'b0, 1'b0, 1'b0, 16'h0F0F);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (col_n === 1'b0) done = 1'b1;
    end
    check("rst_mid_slot_granted", 32'(done), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_colorram", 32'(col_n), 32'd1);
    check("rst_mid_wr_uds", 32'(wr_uds_n), 32'd1);
    check("rst_mid_wr_lds", 32'(wr_lds_n), 32'd1);
    check("rst_mid_dtack", 32'(dtack_n), 32'd1);
    tick();
    release_bus();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Back-to-back reads, each taking its own slot.
    push_exp(11'h123, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    start(11'h123, 1'b1, 1'b0, 1'b0, 16'h0000);
    finish_cycle("read_back_1");
    push_exp(11'h010, 1'b1, 16'h12AB, 16'h12AB, 1'b0, 1'b0);
    start(11'h010, 1'b1, 1'b0, 1'b0, 16'h0000);
    finish_cycle("read_back_2");

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/colorram_cpu_port.md
# colorram_cpu_port

CPU-side access port to the 2K×16 color RAM. It arbitrates 68000 bus cycles against the video palette lookup, which reads the RAM continuously with `i_CD`. Each CPU cycle is granted one full 6 MHz pixel slot, during which the RAM address mux is switched to the CPU. Read data is captured, and DTACK is returned. This block drives the mux select, address, write strobes and write data that the palette lookup and RGB latch consume.

## Interface
Parameters:
- `SNOW_FREE`, default 1: 1 = grant only while `i_BLK`=0 (blanking); 0 = grant at the next pixel slot regardless of blanking.
- `WAIT_LIMIT`, default 512: pixel enables spent waiting before a grant is forced; 10-bit counter; legal range 1..1023.

Ports:
- `i_EMU_MCLK` in 1: master clock, the only clock.
- `i_MRST` in 1: reset, asynchronous, active-high.
- `i_EMU_CLK6MPCEN_n` in 1: pixel clock enable, active-low, one MCLK wide.
- `i_BLK` in 1: 1 = visible, 0 = blanking.
- `i_CD` in 11: video color code.
- `i_COLORRAM_CS_n` in 1: decoded color RAM select.
- `i_CPU_AS_n` in 1: 68000 address strobe.
- `i_CPU_RW` in 1: 1 = read.
- `i_CPU_UDS_n` in 1: upper data strobe.
- `i_CPU_LDS_n` in 1: lower data strobe.
- `i_CPU_ADDR` in 11: CPU word address.
- `i_CPU_DIN` in 16: CPU write data.
- `o_CPU_DOUT` out 16: read data to CPU.
- `o_DTACK_n` out 1: data acknowledge.
- `o_COLORRAM_n` out 1: 0 = CPU owns the RAM.
- `o_RAM_ADDR` out 11: RAM address.
- `o_RAM_DIN` out 16: RAM write data.
- `o_RAM_WR_UDS_n` out 1: high-byte write enable.
- `o_RAM_WR_LDS_n` out 1: low-byte write enable.
- `i_RAM_DOUT` in 16: registered RAM read data.

## Operation
- Reset values: `o_DTACK_n`=1, `o_COLORRAM_n`=1, both write strobes =1, `o_CPU_DOUT`=0, `o_RAM_DIN`=0, state IDLE, wait counter 0.
- `o_RAM_ADDR` is the captured CPU address when `o_COLORRAM_n`=0, otherwise `i_CD` (combinational mux).
- IDLE:
  - Start condition: `i_COLORRAM_CS_n`=0, `i_CPU_AS_n`=0, and at least one data strobe low.
  - On start, capture address, RW, UDS/LDS and DIN, then go to WAIT_SLOT.
  - Clear the counter on entry to WAIT_SLOT.
- WAIT_SLOT:
  - On each pixel enable, grant if `SNOW_FREE`=0, `i_BLK`=0, or counter+1 ≥ `WAIT_LIMIT`. Otherwise increment the counter (saturating).
  - Grant → ACCESS.
  - `i_CPU_AS_n`=1 → IDLE, with no RAM access.
- ACCESS:
  - Lasts from the granting enable to the next pixel enable, exclusive.
  - `o_COLORRAM_n`=0 for the whole slot.
  - On writes, `o_RAM_WR_UDS_n`/`o_RAM_WR_LDS_n` equal the captured strobes; on reads both stay 1.
  - On the closing pixel enable:
    - reads load `o_CPU_DOUT` from `i_RAM_DOUT`;
    - release the mux;
    - go to ACK, or to IDLE if AS has risen meanwhile. The slot always completes.
- ACK: `o_DTACK_n`=0 until `i_CPU_AS_n`=1, then `o_DTACK_n`=1 and IDLE.
- Writes never change `o_CPU_DOUT`.

## Timing
- All state is registered on `i_EMU_MCLK`. `o_COLORRAM_n`, strobes and DTACK are registered outputs.
- The capture cycle is the MCLK after the start condition.
- `o_COLORRAM_n` falls on the MCLK after the granting enable and rises on the MCLK after the closing enable. The slot is exactly one pixel period, i.e. enable-to-enable MCLK count.
- `o_DTACK_n` falls together with the `o_COLORRAM_n` rise.
- Best-case latency, start to DTACK, is one to two pixel periods plus 2 MCLK.
- A new cycle is accepted only in IDLE, so back-to-back CPU cycles each take a fresh slot.
- A pixel enable in the same MCLK as the capture is not used as a grant.
- `i_MRST` mid-ACCESS releases the mux and strobes immediately (asynchronous). A partial write is acceptable.

## Structure
- Shared package `salamander_pkg`: state encoding (IDLE, WAIT_SLOT, ACCESS, ACK), `COLORRAM_AW`=11, `COLORRAM_DW`=16.
- Single module. No sub-module is natural; the wait counter stays inline.

## Test plan
- Reset asserted: outputs at their reset values, and `o_RAM_ADDR` follows `i_CD`=0x2A5.
- Word write of 0x7FFF to 0x123 with `i_BLK`=0:
  - exactly one slot with `o_COLORRAM_n`=0 and `o_RAM_ADDR`=0x123;
  - RAM[0x123]=0x7FFF;
  - DTACK low until AS rises.
- LDS-only write of 0x00AB over RAM[0x010]=0x1234 → 0x12AB; `o_RAM_WR_UDS_n` never low.
- Read of 0x010 with `SNOW_FREE`=1 while `i_BLK`=1 for 100 enables:
  - no grant until `i_BLK` falls;
  - `o_CPU_DOUT`=0x12AB;
  - `o_RAM_ADDR`=`i_CD` throughout the wait.
- `WAIT_LIMIT`=4 with `i_BLK` stuck at 1: grant on the 4th pixel enable after capture.
- AS deasserted in WAIT_SLOT → no write, DTACK stays 1. `i_MRST` pulsed mid-ACCESS → `o_COLORRAM_n` and strobes return to 1 within the reset cycle.
